// File: rtl/pong_game_ctrl_if.sv
// Pong game-controller port bundle: tick/start/paddle inputs, ball/score/state outputs.
// The master side drives the game inputs; the slave side is the controller.
interface pong_game_ctrl_if;
  logic        tick;
  logic        start;
  logic [10:0] P1y;
  logic [10:0] P2y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  p1_score;
  logic [3:0]  p2_score;
  logic [1:0]  state;
  logic        game_over;
  logic        last_point;

  modport master (
    output tick, start, P1y, P2y,
    input  ball_x, ball_y, p1_score, p2_score, state, game_over, last_point
  );

  modport slave (
    input  tick, start, P1y, P2y,
    output ball_x, ball_y, p1_score, p2_score, state, game_over, last_point
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, wall/paddle bounces, scoring and serve/play/over FSM.
// All outputs registered; ball position updates only on tick edges (SERVE holds it at centre).
module pong_game_ctrl #(
  parameter int LEFT_B      = 256,
  parameter int RIGHT_B     = 1024,
  parameter int TOP_B       = 128,
  parameter int BOTTOM_B    = 896,
  parameter int P1_X        = 266,
  parameter int P2_X        = 989,
  parameter int PAD_W       = 25,
  parameter int PAD_H       = 125,
  parameter int BALL_R      = 15,
  parameter int SPEED       = 4,
  parameter int CENTER_X    = 640,
  parameter int CENTER_Y    = 512,
  parameter int SERVE_TICKS = 8,
  parameter int WIN_SCORE   = 7
) (
  input  logic             clock,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Extra headroom bit keeps coordinate sums and paddle ranges from wrapping.
  typedef logic signed [12:0] coord_t;

  localparam coord_t C_LEFT   = coord_t'(LEFT_B);
  localparam coord_t C_RIGHT  = coord_t'(RIGHT_B);
  localparam coord_t C_TOP    = coord_t'(TOP_B);
  localparam coord_t C_BOT    = coord_t'(BOTTOM_B);
  localparam coord_t C_P1_EDGE = coord_t'(P1_X + PAD_W);
  localparam coord_t C_P2_X   = coord_t'(P2_X);
  localparam coord_t C_PAD_H  = coord_t'(PAD_H);
  localparam coord_t C_R      = coord_t'(BALL_R);
  localparam coord_t C_SPEED  = coord_t'(SPEED);

  localparam logic [10:0] CX        = 11'(CENTER_X);
  localparam logic [10:0] CY        = 11'(CENTER_Y);
  localparam logic [10:0] X_BOUNCE1 = 11'(P1_X + PAD_W + BALL_R);
  localparam logic [10:0] X_BOUNCE2 = 11'(P2_X - BALL_R);
  localparam logic [10:0] Y_TOP     = 11'(TOP_B + BALL_R);
  localparam logic [10:0] Y_BOT     = 11'(BOTTOM_B - BALL_R);

  localparam int                CNT_W      = $clog2(SERVE_TICKS) + 1;
  localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [3:0]        WIN        = 4'(WIN_SCORE);

  state_t           state_q, state_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;   // 0 = +1, 1 = -1
  logic [3:0]       p1_q, p1_d, p2_q, p2_d;
  logic             last_q, last_d;
  logic             over_q, over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  coord_t      nx, ny, p1_top, p1_bot, p2_top, p2_bot;
  logic        hit_l, hit_r, score_p1, score_p2;
  logic [10:0] wx, wy;
  logic        wdx, wdy;

  // Candidate next position and its collision outcome.
  always_comb begin
    nx     = coord_t'({2'b00, x_q}) + (dx_q ? -C_SPEED : C_SPEED);
    ny     = coord_t'({2'b00, y_q}) + (dy_q ? -C_SPEED : C_SPEED);
    p1_top = coord_t'({2'b00, bus.P1y});
    p1_bot = p1_top + C_PAD_H;
    p2_top = coord_t'({2'b00, bus.P2y});
    p2_bot = p2_top + C_PAD_H;

    hit_l    = dx_q && (nx - C_R <= C_P1_EDGE) && (ny >= p1_top) && (ny <= p1_bot);
    hit_r    = !dx_q && (nx + C_R >= C_P2_X) && (ny >= p2_top) && (ny <= p2_bot);
    score_p2 = !hit_l && !hit_r && (nx - C_R <= C_LEFT);
    score_p1 = !hit_l && !hit_r && !score_p2 && (nx + C_R >= C_RIGHT);

    wx  = nx[10:0];
    wdx = dx_q;
    if (hit_l) begin
      wdx = 1'b0;
      wx  = X_BOUNCE1;
    end else if (hit_r) begin
      wdx = 1'b1;
      wx  = X_BOUNCE2;
    end

    wy  = ny[10:0];
    wdy = dy_q;
    if (ny - C_R <= C_TOP) begin
      wdy = 1'b0;
      wy  = Y_TOP;
    end else if (ny + C_R >= C_BOT) begin
      wdy = 1'b1;
      wy  = Y_BOT;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        x_d = CX;
        y_d = CY;
        if (bus.start) begin
          state_d = S_SERVE;
          cnt_d   = '0;
        end
      end
      S_SERVE: begin
        x_d = CX;
        y_d = CY;
        if (bus.tick) begin
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.tick) begin
          if (score_p1 || score_p2) begin
            // Ball stays put this edge; SERVE recentres it on the next clock.
            dx_d   = score_p2;
            dy_d   = ~dy_q;
            last_d = score_p2;
            cnt_d  = '0;
            if (score_p1) p1_d = p1_q + 4'd1;
            else          p2_d = p2_q + 4'd1;
            state_d = ((score_p1 ? p1_d : p2_d) == WIN) ? S_OVER : S_SERVE;
          end else begin
            x_d  = wx;
            y_d  = wy;
            dx_d = wdx;
            dy_d = wdy;
          end
        end
      end
      S_OVER: begin
        if (bus.start) begin
          state_d = S_SERVE;
          p1_d    = '0;
          p2_d    = '0;
          x_d     = CX;
          y_d     = CY;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= CX;
      y_q     <= CY;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
      last_q  <= 1'b0;
      over_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      last_q  <= last_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ball_x     = x_q;
  assign bus.ball_y     = y_q;
  assign bus.p1_score   = p1_q;
  assign bus.p2_score   = p2_q;
  assign bus.state      = state_q;
  assign bus.game_over  = over_q;
  assign bus.last_point = last_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench: a default controller (WIN_SCORE=7) and a WIN_SCORE=2 copy driven in lockstep.
module tb_pong_game_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick;
  logic        start;
  logic [10:0] p1y;
  logic [10:0] p2y;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  pong_game_ctrl_if if_a ();
  pong_game_ctrl_if if_b ();

  assign if_a.tick  = tick;
  assign if_a.start = start;
  assign if_a.P1y   = p1y;
  assign if_a.P2y   = p2y;
  assign if_b.tick  = tick;
  assign if_b.start = start;
  assign if_b.P1y   = p1y;
  assign if_b.P2y   = p2y;

  pong_game_ctrl dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  pong_game_ctrl #(.WIN_SCORE(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ball_a(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, 32'(if_a.ball_x), ex);
    chk({tag, "_y"}, 32'(if_a.ball_y), ey);
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    start = 1'b0;
    p1y   = 11'd500;
    p2y   = 11'd760;
    cyc();
    cyc();
    reset = 1'b0;

    chk("rst_state", 32'(if_a.state), 0);
    chk_ball_a("rst_ball", 640, 512);
    chk("rst_p1", 32'(if_a.p1_score), 0);
    chk("rst_p2", 32'(if_a.p2_score), 0);
    chk("rst_over", 32'(if_a.game_over), 0);
    chk("rst_last", 32'(if_a.last_point), 0);

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("idle_tick_ignored", 32'(if_a.state), 0);

    // start and tick together: the tick must not count toward the serve
    start = 1'b1;
    tick  = 1'b1;
    cyc();
    start = 1'b0;
    tick  = 1'b0;
    chk("to_serve", 32'(if_a.state), 1);
    tick_n(7);
    chk("serve_7_ticks", 32'(if_a.state), 1);
    tick_n(1);
    chk("serve_8_ticks", 32'(if_a.state), 2);
    chk_ball_a("play_entry", 640, 512);
    tick_n(1);
    chk_ball_a("first_move", 644, 516);

    tick_n(83);
    chk_ball_a("paddle2_bounce", 974, 848);
    tick_n(1);
    chk_ball_a("after_bounce", 970, 852);

    reset = 1'b1;
    tick  = 1'b1;
    cyc();
    reset = 1'b0;
    tick  = 1'b0;
    chk("rst_mid_state", 32'(if_a.state), 0);
    chk_ball_a("rst_mid_ball", 640, 512);
    chk("rst_mid_p1", 32'(if_a.p1_score), 0);
    chk("rst_mid_over", 32'(if_a.game_over), 0);
    chk("rst_mid_b_state", 32'(if_b.state), 0);

    p1y   = 11'd500;
    p2y   = 11'd20;
    start = 1'b1;
    cyc();
    start = 1'b0;
    tick_n(8);
    chk("b_play", 32'(if_a.state), 2);
    tick_n(92);
    chk_ball_a("pre_miss", 1008, 880);

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_ball_a("miss_hold", 1008, 880);
    chk("miss_p1", 32'(if_a.p1_score), 1);
    chk("miss_p2", 32'(if_a.p2_score), 0);
    chk("miss_last", 32'(if_a.last_point), 0);
    chk("miss_state", 32'(if_a.state), 1);
    chk("miss_b_state", 32'(if_b.state), 1);
    cyc();
    chk_ball_a("recentre", 640, 512);

    tick_n(8);
    chk("reserve_play", 32'(if_a.state), 2);
    tick_n(1);
    chk_ball_a("serve_move", 644, 508);
    tick_n(91);
    chk_ball_a("paddle2_top", 974, 144);
    tick_n(1);
    chk_ball_a("top_clamp", 970, 143);
    tick_n(1);
    chk_ball_a("top_after", 966, 147);

    p1y = 11'd700;
    tick_n(165);
    chk_ball_a("paddle1_bounce", 306, 807);
    tick_n(175);
    chk_ball_a("pre_miss2", 1006, 257);

    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("b_over_state", 32'(if_b.state), 3);
    chk("b_over_flag", 32'(if_b.game_over), 1);
    chk("b_over_p1", 32'(if_b.p1_score), 2);
    chk("b_over_x", 32'(if_b.ball_x), 1006);
    chk("b_over_y", 32'(if_b.ball_y), 257);
    chk("a_serve_state", 32'(if_a.state), 1);
    chk("a_p1_two", 32'(if_a.p1_score), 2);

    tick_n(2);
    chk("b_frozen_x", 32'(if_b.ball_x), 1006);
    chk("b_frozen_y", 32'(if_b.ball_y), 257);
    chk("b_frozen_state", 32'(if_b.state), 3);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("b_restart_state", 32'(if_b.state), 1);
    chk("b_restart_p1", 32'(if_b.p1_score), 0);
    chk("b_restart_p2", 32'(if_b.p2_score), 0);
    chk("b_restart_over", 32'(if_b.game_over), 0);
    chk("b_restart_x", 32'(if_b.ball_x), 640);
    chk("b_restart_y", 32'(if_b.ball_y), 512);
    chk("a_start_ignored", 32'(if_a.state), 1);
    chk("a_score_kept", 32'(if_a.p1_score), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
